// File: rtl/act_quant_stream.sv
// Leaky-ReLU + shift requantiser between the conv2d layer and the next stage.
// Captures a packed tensor and streams saturated narrow elements over valid/ready.
// Optional build macro ACT_QUANT_ROUND_EN selects round-half-up instead of floor.
module act_quant_stream #(
  parameter int NUM_ELEMS   = 4,
  parameter int DATA_WIDTH  = 32,
  parameter int OUT_WIDTH   = 8,
  parameter int LEAKY_MUL   = 13,
  parameter int LEAKY_SHIFT = 7,
  parameter int QUANT_SHIFT = 4,
  localparam int IDX_W      = (NUM_ELEMS > 1) ? $clog2(NUM_ELEMS) : 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  input  logic [NUM_ELEMS*DATA_WIDTH-1:0]   in_tensor_flat,
  output logic                              busy,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [OUT_WIDTH-1:0]              out_data,
  output logic [IDX_W-1:0]                  out_index,
  output logic                              out_last,
  output logic                              done,
  output logic [15:0]                       sat_count
);

  // Product width holds DATA_WIDTH x 16-bit unsigned multiplier without overflow.
  localparam int PW = DATA_WIDTH + 17;
  localparam int RW = PW + 1;

  localparam logic [IDX_W-1:0]        LAST_IDX   = IDX_W'(NUM_ELEMS - 1);
  localparam logic signed [PW-1:0]    MUL_EXT    = PW'(LEAKY_MUL & 16'hFFFF);
  localparam int                      RND_POS    = (QUANT_SHIFT > 0) ? QUANT_SHIFT - 1 : 0;
  localparam logic signed [RW-1:0]    ROUND_BIAS = (QUANT_SHIFT > 0) ? (RW'(1) << RND_POS) : '0;
  localparam longint                  Q_MAX_L    = (64'sd1 <<< (OUT_WIDTH - 1)) - 64'sd1;
  localparam logic signed [RW-1:0]    Q_MAX      = RW'(Q_MAX_L);
  localparam logic signed [RW-1:0]    Q_MIN      = RW'(-Q_MAX_L - 64'sd1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2
  } state_t;

  state_t state, state_next;

  logic                            arm;
  logic [NUM_ELEMS*DATA_WIDTH-1:0] buffer;
  logic [IDX_W-1:0]                idx;

  logic capture;
  logic load_en;
  logic accept;

  logic signed [DATA_WIDTH-1:0] x_sel;
  logic signed [PW-1:0]         x_ext;
  logic signed [PW-1:0]         leaky_prod;
  logic signed [PW-1:0]         y;
  logic signed [RW-1:0]         y_wide;
  logic signed [RW-1:0]         q;
  logic                         sat_hi;
  logic                         sat_lo;
  logic                         f_sat;
  logic [OUT_WIDTH-1:0]         f_data;

  // NOTE: sequential state uses non-blocking assignments so every register
  // updates from the values present before the clock edge.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: every signal driven in always_comb gets a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (capture) state_next = LOAD;
      LOAD:    state_next = SEND;
      SEND:    if (accept) state_next = out_last ? IDLE : LOAD;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    capture = 1'b0;
    load_en = 1'b0;
    accept  = 1'b0;
    case (state)
      IDLE:    capture = in_valid && arm;
      LOAD:    load_en = 1'b1;
      SEND:    accept  = out_valid && out_ready;
      default: ;
    endcase
  end

  // Leaky-ReLU, requantising shift and clamp for the element at idx.
  always_comb begin
    x_sel      = buffer[idx*DATA_WIDTH +: DATA_WIDTH];
    x_ext      = {{17{x_sel[DATA_WIDTH-1]}}, x_sel};
    leaky_prod = x_ext * MUL_EXT;
    y          = x_sel[DATA_WIDTH-1] ? (leaky_prod >>> LEAKY_SHIFT) : x_ext;
    y_wide     = {y[PW-1], y};
`ifdef ACT_QUANT_ROUND_EN
    q          = (y_wide + ROUND_BIAS) >>> QUANT_SHIFT;
`else
    q          = y_wide >>> QUANT_SHIFT;
`endif
    sat_hi     = q > Q_MAX;
    sat_lo     = q < Q_MIN;
    f_sat      = sat_hi | sat_lo;
    if (sat_hi)      f_data = Q_MAX[OUT_WIDTH-1:0];
    else if (sat_lo) f_data = Q_MIN[OUT_WIDTH-1:0];
    else             f_data = q[OUT_WIDTH-1:0];
  end

  // NOTE: the capture buffer is reset along with the control state, so a
  // reset mid-stream leaves no stale tensor behind.
  always_ff @(posedge clk) begin
    if (rst) begin
      arm       <= 1'b1;
      buffer    <= '0;
      idx       <= '0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      done      <= 1'b0;
      out_data  <= '0;
      out_index <= '0;
      sat_count <= '0;
    end else begin
      done <= 1'b0;

      // arm re-opens only once in_valid has been seen low, so a held level never re-captures.
      if (capture)        arm <= 1'b0;
      else if (!in_valid) arm <= 1'b1;

      if (capture) begin
        buffer <= in_tensor_flat;
        idx    <= '0;
        busy   <= 1'b1;
      end

      if (load_en) begin
        out_data  <= f_data;
        out_index <= idx;
        out_last  <= (idx == LAST_IDX);
        out_valid <= 1'b1;
        if (f_sat && (sat_count != 16'hFFFF)) sat_count <= sat_count + 16'd1;
      end

      if (accept) begin
        out_valid <= 1'b0;
        if (out_last) begin
          busy <= 1'b0;
          done <= 1'b1;
        end else begin
          idx <= idx + IDX_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_act_quant_stream.sv
// Scoreboard bench for act_quant_stream: stimulus pushes model results, a monitor
// pops and compares on every handshake. Honours ACT_QUANT_ROUND_EN like the DUT.
module tb_act_quant_stream;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int OW = 8;
  localparam int LM = 13;
  localparam int LS = 7;
  localparam int QS = 4;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic [N*DW-1:0] in_tensor_flat;
  logic            busy;
  logic            out_valid;
  logic            out_ready;
  logic [OW-1:0]   out_data;
  logic [IW-1:0]   out_index;
  logic            out_last;
  logic            done;
  logic [15:0]     sat_count;

  act_quant_stream #(
    .NUM_ELEMS(N), .DATA_WIDTH(DW), .OUT_WIDTH(OW),
    .LEAKY_MUL(LM), .LEAKY_SHIFT(LS), .QUANT_SHIFT(QS)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_tensor_flat(in_tensor_flat),
    .busy(busy), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_index(out_index), .out_last(out_last), .done(done), .sat_count(sat_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int data;
    int idx;
    bit last;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   done_seen = 0;
  int   stall_cycles = 0;
  int   stall_left = 0;
  int   sat_exp = 0;
  int   ready_mode = 0;

  bit            prev_stall = 1'b0;
  logic [OW-1:0] held_data;
  logic [IW-1:0] held_index;
  logic          held_last;

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: leaky slope 13/128 with floor, then shift (floor or round-half-up), then clamp.
  function automatic int model_f(input longint x, output bit sat);
    longint y, q, hi, lo;
    y = (x < 0) ? ((x * LM) >>> LS) : x;
`ifdef ACT_QUANT_ROUND_EN
    q = (QS > 0) ? ((y + (longint'(1) << (QS - 1))) >>> QS) : y;
`else
    q = y >>> QS;
`endif
    hi  = (longint'(1) << (OW - 1)) - 1;
    lo  = -hi - 1;
    sat = (q > hi) || (q < lo);
    if (q > hi) q = hi;
    if (q < lo) q = lo;
    return int'(q);
  endfunction

  task automatic push_tensor(input logic [N*DW-1:0] t);
    bit s;
    int d;
    for (int i = 0; i < N; i++) begin
      d = model_f(longint'($signed(t[i*DW +: DW])), s);
      sb.push_back('{d, i, (i == N - 1)});
      if (s && sat_exp < 65535) sat_exp++;
    end
  endtask

  function automatic logic [N*DW-1:0] rand_tensor();
    logic [N*DW-1:0] t;
    logic [DW-1:0]   v;
    for (int i = 0; i < N; i++) begin
      case ($urandom_range(0, 3))
        0:       v = DW'($urandom_range(0, 4000)) - DW'(2000);
        1:       v = DW'($urandom_range(0, 80000)) - DW'(40000);
        2:       v = DW'($urandom());
        default: v = DW'($urandom_range(2000, 2100)) ^ ({DW{$urandom_range(0, 1) == 1}});
      endcase
      t[i*DW +: DW] = v;
    end
    return t;
  endfunction

  // Monitor: compares every handshake against the scoreboard and checks stall stability.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (done) done_seen++;
      if (prev_stall) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, held_data);
        check("hold_index", out_index, held_index);
        check("hold_last", out_last, held_last);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_output: got index %0d data %0d, expected no output (t=%0t)",
                   out_index, $signed(out_data), $time);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("out_data", $signed(out_data), e.data);
          check("out_index", out_index, e.idx);
          check("out_last", out_last, e.last);
        end
      end
      prev_stall = out_valid && !out_ready;
      if (prev_stall) stall_cycles++;
      held_data  = out_data;
      held_index = out_index;
      held_last  = out_last;
    end
  end

  // Downstream ready driver.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: out_ready = 1'b1;
        1: out_ready = ($urandom_range(0, 1) == 1);
        2: begin
          if (out_valid && out_index == 2'd1 && stall_left > 0) begin
            out_ready = 1'b0;
            stall_left--;
          end else begin
            out_ready = 1'b1;
          end
        end
        default: out_ready = !(out_valid && out_index == 2'd2);
      endcase
    end
  end

  // Raise in_valid with tensor t for 'hold' cycles, checking first-output latency.
  task automatic capture(input logic [N*DW-1:0] t, input int hold);
    int cyc;
    @(posedge clk);
    #1;
    in_tensor_flat = t;
    in_valid       = 1'b1;
    push_tensor(t);
    @(posedge clk);
    #1;
    in_tensor_flat = rand_tensor();
    cyc = 1;
    if (cyc >= hold) in_valid = 1'b0;
    @(negedge clk);
    check("valid_low_after_capture", out_valid, 0);
    @(posedge clk);
    #1;
    cyc = 2;
    if (cyc >= hold) in_valid = 1'b0;
    @(negedge clk);
    check("first_valid_latency", out_valid, 1);
    while (cyc < hold) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int cyc = 0;
    while (done_seen < target && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    repeat (3) @(negedge clk);
    check("done_pulses", done_seen, target);
    check("sb_drained", sb.size(), 0);
    check("busy_idle", busy, 0);
    check("sat_count", sat_count, sat_exp);
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N*DW-1:0] t;
    int              vals [N];
    int              cyc;

    rst            = 1'b1;
    in_valid       = 1'b0;
    in_tensor_flat = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_done", done, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_index", out_index, 0);
    check("rst_sat_count", sat_count, 0);

    // Directed tensor, in_valid held for 20 cycles: exactly one stream.
    vals = '{256, -1280, 5000, -100000};
    for (int i = 0; i < N; i++) t[i*DW +: DW] = DW'(vals[i]);
    capture(t, 20);
    wait_done(1);

    // Five-cycle stall on element 1.
    ready_mode   = 2;
    stall_left   = 5;
    stall_cycles = 0;
    capture(rand_tensor(), 1);
    wait_done(2);
    check("stall_cycles", stall_cycles, 5);

    // in_valid pulses while busy are ignored; a fresh edge after done is captured.
    ready_mode = 0;
    capture(rand_tensor(), 1);
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1;
      check("busy_during_pulse", busy, 1);
      in_tensor_flat = rand_tensor();
      in_valid       = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
    wait_done(3);
    capture(rand_tensor(), 1);
    wait_done(4);

    // Reset while element 2 is waiting in SEND.
    ready_mode = 3;
    capture(rand_tensor(), 1);
    cyc = 0;
    while (!(out_valid && out_index == 2'd2) && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("reach_elem2_valid", out_valid, 1);
    check("reach_elem2_index", out_index, 2);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    sat_exp = 0;
    @(negedge clk);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_out_last", out_last, 0);
    check("mid_rst_out_data", out_data, 0);
    check("mid_rst_out_index", out_index, 0);
    check("mid_rst_sat_count", sat_count, 0);
    ready_mode = 0;
    capture(rand_tensor(), 1);
    wait_done(5);

    // Randomised tensors, hold lengths and back-pressure.
    ready_mode = 1;
    for (int k = 0; k < 25; k++) begin
      capture(rand_tensor(), $urandom_range(1, 6));
      wait_done(6 + k);
    end

    // Saturation counter sticks at 0xFFFF.
    ready_mode = 0;
    @(negedge clk);
    force dut.sat_count = 16'hFFFE;
    @(posedge clk);
    #1;
    release dut.sat_count;
    sat_exp = 65534;
    @(negedge clk);
    check("sat_preload", sat_count, sat_exp);
    vals = '{5000, -100000, 32'h7FFF_FFFF, 32'h8000_0000};
    for (int i = 0; i < N; i++) t[i*DW +: DW] = DW'(vals[i]);
    capture(t, 1);
    wait_done(31);
    check("sat_sticky", sat_count, 65535);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
